// File: rtl/rv_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_bus_pkg
// Purpose  : Shared types and constants for the RV32 bus sequencer.
//            Holds the sequencer state encoding, the trap cause codes and
//            the NOP instruction that Instr holds out of reset.
// Revision : 1.0 - initial release
// ============================================================================
package rv_bus_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    DATA  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_BUSERR   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_MISALIGN = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : rv_bus_pkg
`default_nettype wire

// File: rtl/rv_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module   : rv_bus_timeout
// Purpose  : Wait-state counter for one bus request. expired is high in the
//            last wait cycle the sequencer is allowed to spend on a request,
//            so the trap is taken on the edge that ends the
//            TIMEOUT_CYCLES-th wait cycle.
// Ports    : clk, reset   - clock, asynchronous active-high reset
//            start        - clear the counter (no request in flight)
//            waiting      - request pending with neither ack nor error
//            expired      - wait budget used up in this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rv_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic waiting,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      // Timeout switched off: nothing to count.
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, start, waiting};
      assign expired  = 1'b0;
    end else begin : g_enabled
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (start) begin
          r_cnt <= '0;
        end else if (waiting) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // r_cnt holds the number of wait cycles already spent, so this cycle is
      // the TIMEOUT_CYCLES-th one when the count equals TIMEOUT_CYCLES-1.
      assign expired = waiting && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule : rv_bus_timeout
`default_nettype wire

// File: rtl/rv_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rv_bus_sequencer
// Purpose  : Multi-cycle sequencer that runs the single-cycle RV32 datapath
//            against one shared req/ack memory bus. Fetches an instruction,
//            holds it for decode, performs at most one load/store, then
//            pulses CoreEn to commit. Traps (sticky) on bus error, timeout
//            or misaligned fetch.
// Ports    : clk, reset                   - clock, async active-high reset
//            PC, MemRead, MemWrite,
//            ALUResult, WriteData, ByteEn - datapath/controller side
//            Instr, ReadData, CoreEn      - back to the datapath
//            bus_*                        - memory request/response bus
//            fault, fault_cause,
//            fault_addr, instret          - status
// Revision : 1.0 - initial release
// ============================================================================
module rv_bus_sequencer
  import rv_bus_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     PC,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [XLEN-1:0]     ALUResult,
  input  logic [XLEN-1:0]     WriteData,
  input  logic [XLEN/8-1:0]   ByteEn,
  output logic [XLEN-1:0]     Instr,
  output logic [XLEN-1:0]     ReadData,
  output logic                CoreEn,
  output logic                bus_req,
  output logic                bus_we,
  output logic [XLEN-1:0]     bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [XLEN/8-1:0]   bus_be,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [XLEN-1:0]     bus_rdata,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic [XLEN-1:0]     fault_addr,
  output logic [CNT_W-1:0]    instret
);

  localparam int BW = XLEN / 8;

  state_t           r_state;
  logic [XLEN-1:0]  r_instr;
  logic [XLEN-1:0]  r_rdata;
  logic [CNT_W-1:0] r_instret;
  logic             r_fault;
  logic [1:0]       r_cause;
  logic [XLEN-1:0]  r_faddr;

  logic             w_mem_op;
  logic             w_misalign;
  logic             w_req;
  logic             w_store;
  logic [XLEN-1:0]  w_addr;
  logic             w_ack;
  logic             w_err;
  logic             w_wait;
  logic             w_expired;
  logic             w_trap;
  logic [1:0]       w_trap_cause;

  assign w_mem_op   = MemRead | MemWrite;
  assign w_misalign = |PC[1:0];

  // Request is a pure decode of the registered state. PC and ALUResult are
  // held steady by the datapath while CoreEn is low, so the address stays
  // stable for the whole request. Reset gates it so an aborted request drops
  // immediately rather than on the next edge.
  assign w_req   = !reset && (((r_state == FETCH) && !w_misalign) || (r_state == DATA));
  assign w_store = (r_state == DATA) && MemWrite;
  assign w_addr  = (r_state == DATA) ? ALUResult : PC;

  // Responses only count while a request is out; error beats ack.
  assign w_err  = w_req && bus_err;
  assign w_ack  = w_req && bus_ack && !bus_err;
  assign w_wait = w_req && !bus_ack && !bus_err;

  rv_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .start  (!w_req),
    .waiting(w_wait),
    .expired(w_expired)
  );

  always_comb begin
    w_trap       = 1'b0;
    w_trap_cause = FC_NONE;
    if ((r_state == FETCH) && w_misalign) begin
      w_trap       = 1'b1;
      w_trap_cause = FC_MISALIGN;
    end else if (w_err) begin
      w_trap       = 1'b1;
      w_trap_cause = FC_BUSERR;
    end else if (w_expired) begin
      w_trap       = 1'b1;
      w_trap_cause = FC_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instr   <= XLEN'(NOP_INSTR);
      r_rdata   <= '0;
      r_instret <= '0;
      r_fault   <= 1'b0;
      r_cause   <= FC_NONE;
      r_faddr   <= '0;
    end else if (w_trap) begin
      r_state <= HALT;
      r_fault <= 1'b1;
      r_cause <= w_trap_cause;
      r_faddr <= w_addr;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack) begin
            r_instr <= bus_rdata;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_mem_op) begin
            r_state <= DATA;
          end else begin
            r_instret <= r_instret + CNT_W'(1);
            r_state   <= FETCH;
          end
        end
        DATA: begin
          if (w_ack) begin
            if (!MemWrite) r_rdata <= bus_rdata;
            r_state <= WB;
          end
        end
        WB: begin
          r_instret <= r_instret + CNT_W'(1);
          r_state   <= FETCH;
        end
        HALT:    r_state <= HALT;
        default: r_state <= HALT;
      endcase
    end
  end

  // Commit depends on the decode of the instruction held in Instr during
  // EXEC, so it is a decode of state plus MemRead/MemWrite.
  assign CoreEn = !reset && (((r_state == EXEC) && !w_mem_op) || (r_state == WB));

  assign bus_req   = w_req;
  assign bus_we    = w_req && w_store;
  assign bus_addr  = w_req ? w_addr : '0;
  assign bus_wdata = (w_req && w_store) ? WriteData : '0;
  assign bus_be    = !w_req ? '0 : (w_store ? ByteEn : {BW{1'b1}});

  assign Instr       = r_instr;
  assign ReadData    = r_rdata;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign fault_addr  = r_faddr;
  assign instret     = r_instret;

endmodule : rv_bus_sequencer
`default_nettype wire

// File: tb/tb_rv_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_bus_sequencer
// Purpose  : Self-checking bench for rv_bus_sequencer. A cycle table drives
//            an ADDI / LW / SW program against a zero-wait memory, followed
//            by hand-written sequences for wait states, traps and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_bus_sequencer;

  localparam logic [31:0] I_NOP  = 32'h0000_0013;
  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A103;
  localparam logic [31:0] I_SW   = 32'h0020_A223;
  localparam logic [31:0] I_ADD2 = 32'h0010_0113;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, ALUResult, WriteData, bus_rdata;
  logic        MemRead, MemWrite, bus_ack, bus_err;
  logic [3:0]  ByteEn;
  logic [31:0] Instr, ReadData, bus_addr, bus_wdata, fault_addr;
  logic        CoreEn, bus_req, bus_we, fault;
  logic [3:0]  bus_be;
  logic [1:0]  fault_cause;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_bus_sequencer #(
    .XLEN(32), .TIMEOUT_CYCLES(4), .CNT_W(64)
  ) dut (
    .clk(clk), .reset(reset), .PC(PC), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ByteEn(ByteEn),
    .Instr(Instr), .ReadData(ReadData), .CoreEn(CoreEn),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_err(bus_err), .bus_rdata(bus_rdata), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .instret(instret)
  );

  typedef struct {
    logic [31:0] pc;
    logic        mr, mw;
    logic [31:0] alu, wd;
    logic [3:0]  be;
    logic        ack, err;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_ce;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    input logic [31:0] pc, input logic mr, input logic mw,
    input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] be,
    input logic ack, input logic err, input logic [31:0] rd,
    input logic e_req, input logic e_we, input logic [31:0] e_addr,
    input logic [31:0] e_wdata, input logic [3:0] e_be, input logic e_ce,
    input logic [31:0] e_instr);
    vec_t v;
    v.pc = pc; v.mr = mr; v.mw = mw; v.alu = alu; v.wd = wd; v.be = be;
    v.ack = ack; v.err = err; v.rd = rd;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_be = e_be; v.e_ce = e_ce; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] be,
                       input logic ack, input logic err, input logic [31:0] rd);
    PC = pc; MemRead = mr; MemWrite = mw; ALUResult = alu; WriteData = wd;
    ByteEn = be; bus_ack = ack; bus_err = err; bus_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release 1 ns after a rising edge so the next full
  // period is cycle 1 in FETCH.
  task automatic do_reset();
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Zero-wait program: ADDI @0, LW @4 (addr 0x100), SW @8 (addr 0x104)
    tbl[0] = mk(32'h0, 0, 0, 32'h0,   32'h0,    4'h0, 1, 0, I_ADDI,       1, 0, 32'h0,   32'h0,    4'hF, 0, I_NOP);
    tbl[1] = mk(32'h0, 0, 0, 32'h0,   32'h0,    4'h0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    4'h0, 1, I_ADDI);
    tbl[2] = mk(32'h4, 0, 0, 32'h0,   32'h0,    4'h0, 1, 0, I_LW,         1, 0, 32'h4,   32'h0,    4'hF, 0, I_ADDI);
    tbl[3] = mk(32'h4, 1, 0, 32'h100, 32'h0,    4'h0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    4'h0, 0, I_LW);
    tbl[4] = mk(32'h4, 1, 0, 32'h100, 32'h0,    4'h0, 1, 0, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0,    4'hF, 0, I_LW);
    tbl[5] = mk(32'h4, 1, 0, 32'h100, 32'h0,    4'h0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    4'h0, 1, I_LW);
    tbl[6] = mk(32'h8, 0, 0, 32'h0,   32'h0,    4'h0, 1, 0, I_SW,         1, 0, 32'h8,   32'h0,    4'hF, 0, I_LW);
    tbl[7] = mk(32'h8, 0, 1, 32'h104, 32'h5678, 4'h3, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    4'h0, 0, I_SW);
    tbl[8] = mk(32'h8, 0, 1, 32'h104, 32'h5678, 4'h3, 1, 0, 32'h0,        1, 1, 32'h104, 32'h5678, 4'h3, 0, I_SW);
    tbl[9] = mk(32'h8, 0, 1, 32'h104, 32'h5678, 4'h3, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,    4'h0, 1, I_SW);

    // ---------------- reset state ----------------
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    chk("rst bus_req", bus_req, 0);
    chk("rst CoreEn", CoreEn, 0);
    chk("rst Instr", Instr, I_NOP);
    chk("rst ReadData", ReadData, 0);
    chk("rst instret", instret, 0);
    chk("rst fault", fault, 0);
    chk("rst fault_cause", fault_cause, 0);
    chk("rst fault_addr", fault_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---------------- table: zero-wait program ----------------
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].pc, tbl[i].mr, tbl[i].mw, tbl[i].alu, tbl[i].wd, tbl[i].be,
            tbl[i].ack, tbl[i].err, tbl[i].rd);
      #1;
      chk($sformatf("cyc%0d bus_req", i + 1), bus_req, tbl[i].e_req);
      chk($sformatf("cyc%0d CoreEn", i + 1), CoreEn, tbl[i].e_ce);
      chk($sformatf("cyc%0d Instr", i + 1), Instr, tbl[i].e_instr);
      if (tbl[i].e_req) begin
        chk($sformatf("cyc%0d bus_we", i + 1), bus_we, tbl[i].e_we);
        chk($sformatf("cyc%0d bus_addr", i + 1), bus_addr, tbl[i].e_addr);
        chk($sformatf("cyc%0d bus_be", i + 1), bus_be, tbl[i].e_be);
        if (tbl[i].e_we) chk($sformatf("cyc%0d bus_wdata", i + 1), bus_wdata, tbl[i].e_wdata);
      end
      step();
    end
    chk("prog instret", instret, 3);
    chk("prog ReadData", ReadData, 32'hDEADBEEF);

    // ---------------- fetch with 3 wait states ----------------
    for (int w = 0; w < 3; w++) begin
      drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      #1;
      chk($sformatf("wait%0d bus_req", w), bus_req, 1);
      chk($sformatf("wait%0d bus_addr", w), bus_addr, 32'hC);
      chk($sformatf("wait%0d Instr held", w), Instr, I_SW);
      step();
    end
    drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, I_ADD2);
    #1;
    chk("wait ack bus_req", bus_req, 1);
    chk("wait ack bus_addr", bus_addr, 32'hC);
    chk("wait ack Instr held", Instr, I_SW);
    step();
    drive(32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("wait Instr updated", Instr, I_ADD2);
    chk("wait EXEC CoreEn", CoreEn, 1);
    chk("wait EXEC bus_req", bus_req, 0);
    step();
    chk("wait instret", instret, 4);
    chk("wait ReadData held", ReadData, 32'hDEADBEEF);

    // ---------------- misaligned fetch ----------------
    drive(32'h102, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("misal bus_req", bus_req, 0);
    step();
    chk("misal fault", fault, 1);
    chk("misal cause", fault_cause, 3);
    chk("misal addr", fault_addr, 32'h102);
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    step();
    chk("misal halt bus_req", bus_req, 0);
    chk("misal halt CoreEn", CoreEn, 0);
    chk("misal halt instret", instret, 4);

    // ---------------- bus error on store DATA request ----------------
    do_reset();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, I_SW);
    step();
    drive(32'h0, 1'b0, 1'b1, 32'h1000, 32'hCAFE, 4'hF, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h0, 1'b0, 1'b1, 32'h1000, 32'hCAFE, 4'hF, 1'b0, 1'b1, 32'h0);
    #1;
    chk("berr bus_req", bus_req, 1);
    chk("berr bus_we", bus_we, 1);
    chk("berr bus_addr", bus_addr, 32'h1000);
    step();
    chk("berr fault", fault, 1);
    chk("berr cause", fault_cause, 1);
    chk("berr addr", fault_addr, 32'h1000);
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("berr halt%0d bus_req", k), bus_req, 0);
      chk($sformatf("berr halt%0d CoreEn", k), CoreEn, 0);
      step();
    end

    // ---------------- ack and error together on fetch ----------------
    do_reset();
    drive(32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step();
    chk("ackerr Instr", Instr, I_NOP);
    chk("ackerr cause", fault_cause, 1);
    chk("ackerr addr", fault_addr, 32'h10);

    // ---------------- timeout (TIMEOUT_CYCLES = 4) ----------------
    do_reset();
    drive(32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    for (int t = 0; t < 4; t++) begin
      #1;
      chk($sformatf("tmo cyc%0d bus_req", t + 1), bus_req, 1);
      chk($sformatf("tmo cyc%0d fault", t + 1), fault, 0);
      step();
    end
    chk("tmo bus_req dropped", bus_req, 0);
    chk("tmo fault", fault, 1);
    chk("tmo cause", fault_cause, 2);
    chk("tmo addr", fault_addr, 32'h20);

    // ---------------- async reset in the middle of DATA ----------------
    do_reset();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, I_ADDI);
    step();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, I_LW);
    step();
    drive(32'h4, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("arst pre bus_req", bus_req, 1);
    chk("arst pre bus_addr", bus_addr, 32'h200);
    chk("arst pre instret", instret, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst bus_req", bus_req, 0);
    chk("arst Instr", Instr, I_NOP);
    chk("arst instret", instret, 0);
    chk("arst CoreEn", CoreEn, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("arst refetch bus_req", bus_req, 1);
    chk("arst refetch bus_we", bus_we, 0);
    chk("arst refetch bus_addr", bus_addr, 32'h40);
    chk("arst refetch bus_be", bus_be, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rv_bus_sequencer
`default_nettype wire
